// File: rtl/buffer_result_packer_pkg.sv
// Shared types and constants for the result packer.
// Byte/word widths, FSM states and the zero pad helper.
package buffer_result_packer_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 4 * BYTE_W;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    PAD   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [BYTE_W-1:0] PAD_BYTE = '0;

  // acc holds the latest bytes in its low lanes; idx = bytes held.
  function automatic logic [WORD_W-1:0] pad_word(
    input logic [3*BYTE_W-1:0] acc,
    input logic [1:0]          idx
  );
    logic [WORD_W-1:0] w;
    w = '0;
    unique case (1'b1)
      (idx == 2'd1): w = {acc[BYTE_W-1:0], {3{PAD_BYTE}}};
      (idx == 2'd2): w = {acc[2*BYTE_W-1:0], {2{PAD_BYTE}}};
      default:       w = {acc, PAD_BYTE};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sync_word_fifo.sv
// Circular word FIFO with occupancy counter.
// Head word reads as zero while empty.
module sync_word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/buffer_result_packer.sv
// Packs result bytes MSB-first into words and queues them.
// Flush zero-pads a partial word and reports once drained.
module buffer_result_packer
  import buffer_result_packer_pkg::*;
#(
  parameter int DEPTH_WORDS = 4,
  localparam int CNT_W = $clog2(DEPTH_WORDS) + 1
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic [BYTE_W-1:0] byteIn,
  input  logic              WEByte,
  output logic              byteReady,
  input  logic              flush,
  output logic [WORD_W-1:0] wordOut,
  output logic              wordValid,
  input  logic              wordReady,
  output logic [CNT_W-1:0]  wordCount,
  output logic              fullPacker,
  output logic              flushDone
);

  state_e              state_q;
  logic [1:0]          idx_q;
  logic [1:0]          idx_d;
  logic [3*BYTE_W-1:0] acc_q;
  logic                take;
  logic                pop;
  logic                pad_go;
  logic                push;
  logic [WORD_W-1:0]   push_word;
  logic                empty;

  assign byteReady = (state_q == ACCUM) && !(idx_q == 2'd3 && fullPacker);
  assign take      = WEByte && byteReady;
  assign pop       = wordValid && wordReady;
  assign idx_d     = take ? idx_q + 2'd1 : idx_q;
  // A pop frees a slot on the same edge, so PAD can push into a full FIFO.
  assign pad_go    = (state_q == PAD) && (!fullPacker || pop);
  assign push      = (take && idx_q == 2'd3) || pad_go;
  assign push_word = (state_q == PAD) ? pad_word(acc_q, idx_q)
                                      : {acc_q, byteIn};
  assign wordValid = !empty;
  assign flushDone = (state_q == DRAIN) && (wordCount == '0);

  sync_word_fifo #(
    .DEPTH(DEPTH_WORDS),
    .WIDTH(WORD_W)
  ) u_fifo (
    .clk  (clk),
    .rstN (rstN),
    .push (push),
    .din  (push_word),
    .pop  (pop),
    .dout (wordOut),
    .full (fullPacker),
    .empty(empty),
    .count(wordCount)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= ACCUM;
      idx_q   <= '0;
      acc_q   <= '0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (take) begin
            acc_q <= {acc_q[2*BYTE_W-1:0], byteIn};
            idx_q <= idx_d;
          end
          if (flush) begin
            state_q <= (idx_d != 2'd0) ? PAD : DRAIN;
          end
        end
        PAD: begin
          if (pad_go) begin
            idx_q   <= '0;
            acc_q   <= '0;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (flushDone) begin
            state_q <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_result_packer.sv
// Bench for buffer_result_packer: table vectors, directed
// corner sequences and random traffic against a queue model.
module tb_buffer_result_packer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstN;
  logic [7:0]  bin;
  logic        we;
  logic        rdy;
  logic        fl;
  logic [31:0] wout;
  logic        wval;
  logic        wr;
  logic [2:0]  wcnt;
  logic        full;
  logic        done;

  buffer_result_packer #(.DEPTH_WORDS(DEPTH)) dut (
    .clk       (clk),
    .rstN      (rstN),
    .byteIn    (bin),
    .WEByte    (we),
    .byteReady (rdy),
    .flush     (fl),
    .wordOut   (wout),
    .wordValid (wval),
    .wordReady (wr),
    .wordCount (wcnt),
    .fullPacker(full),
    .flushDone (done)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;

  logic [31:0] mq[$];
  logic [7:0]  mb[$];
  int          mmode;
  bit          macc;
  logic [31:0] got[$];
  int          ndone;

  typedef struct {
    logic        we;
    logic [7:0]  b;
    logic        wr;
    logic        e_rdy;
    logic        e_val;
    logic [31:0] e_word;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mb.delete();
    mmode = 0;
    macc  = 0;
  endtask

  task automatic model_edge();
    int          cnt0;
    bit          full0;
    bit          pop;
    bit          mrdy;
    logic [31:0] w;
    cnt0  = mq.size();
    full0 = (cnt0 == DEPTH);
    pop   = (cnt0 != 0) && wr;
    mrdy  = (mmode == 0) && !(mb.size() == 3 && full0);
    macc  = we && mrdy;
    if (pop) void'(mq.pop_front());
    case (mmode)
      0: begin
        if (macc) begin
          mb.push_back(bin);
          if (mb.size() == 4) begin
            mq.push_back({mb[0], mb[1], mb[2], mb[3]});
            mb.delete();
          end
        end
        if (fl) mmode = (mb.size() != 0) ? 1 : 2;
      end
      1: begin
        if (!full0 || pop) begin
          w = '0;
          for (int i = 0; i < mb.size(); i++) w[31-8*i -: 8] = mb[i];
          mq.push_back(w);
          mb.delete();
          mmode = 2;
        end
      end
      default: begin
        if (cnt0 == 0) mmode = 0;
      end
    endcase
  endtask

  task automatic cyc();
    int  c;
    bit  mrdy;
    c    = mq.size();
    mrdy = (mmode == 0) && !(mb.size() == 3 && c == DEPTH);
    chk("byteReady", 32'(rdy), 32'(mrdy));
    chk("wordValid", 32'(wval), 32'(c != 0));
    chk("wordOut", wout, (c != 0) ? mq[0] : 32'h0);
    chk("wordCount", 32'(wcnt), 32'(c));
    chk("fullPacker", 32'(full), 32'(c == DEPTH));
    chk("flushDone", 32'(done), 32'(mmode == 2 && c == 0));
    if (wval && wr) got.push_back(wout);
    if (done) ndone++;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [7:0] b);
    bit ok;
    ok  = 0;
    we  = 1'b1;
    bin = b;
    for (int k = 0; k < 50; k++) begin
      cyc();
      if (macc) begin
        ok = 1;
        break;
      end
    end
    we = 1'b0;
    if (!ok) begin
      nvec++;
      nmis++;
      $display("FAIL feed_timeout: got no accept expected accept of %h", b);
    end
  endtask

  initial begin
    logic [31:0] exp5[5];
    bit          seen;

    exp5[0] = 32'h01020304;
    exp5[1] = 32'h05060708;
    exp5[2] = 32'h090A0B0C;
    exp5[3] = 32'h0D0E0F10;
    exp5[4] = 32'h11121314;

    tbl[0] = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 32'h0, 3'd0};
    tbl[1] = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 32'h0, 3'd0};
    tbl[2] = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 32'h0, 3'd0};
    tbl[3] = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 32'h0, 3'd0};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'h11223344, 3'd1};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0, 3'd0};

    rstN = 1'b0;
    we   = 1'b0;
    bin  = 8'h00;
    fl   = 1'b0;
    wr   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;

    chk("reset_flushDone", 32'(done), 32'h0);
    chk("reset_wordOut", wout, 32'h0);

    for (int i = 0; i < 6; i++) begin
      we  = tbl[i].we;
      bin = tbl[i].b;
      wr  = tbl[i].wr;
      chk("tbl_byteReady", 32'(rdy), 32'(tbl[i].e_rdy));
      chk("tbl_wordValid", 32'(wval), 32'(tbl[i].e_val));
      chk("tbl_wordOut", wout, tbl[i].e_word);
      chk("tbl_wordCount", 32'(wcnt), 32'(tbl[i].e_cnt));
      cyc();
    end
    we = 1'b0;

    // Fill to full with wordReady low, then drain in order.
    wr = 1'b0;
    for (int i = 1; i <= 19; i++) begin
      feed(8'(i));
      if (i == 16) chk("full_after16", 32'(full), 32'h1);
    end
    chk("ready_low_full", 32'(rdy), 32'h0);
    got.delete();
    wr = 1'b1;
    feed(8'h14);
    for (int k = 0; k < 30 && got.size() < 5; k++) cyc();
    chk("drain_count", 32'(got.size()), 32'd5);
    for (int k = 0; k < 5; k++)
      chk("drain_word", (k < got.size()) ? got[k] : 32'hX, exp5[k]);

    // Partial flush with zero padding.
    wr = 1'b0;
    feed(8'hAA);
    feed(8'hBB);
    got.delete();
    ndone = 0;
    fl = 1'b1;
    cyc();
    fl = 1'b0;
    wr = 1'b1;
    repeat (8) cyc();
    chk("pad_words", 32'(got.size()), 32'd1);
    chk("pad_word", (got.size() > 0) ? got[0] : 32'hX, 32'hAABB0000);
    chk("pad_done_pulses", 32'(ndone), 32'd1);
    chk("pad_ready_after", 32'(rdy), 32'h1);

    // Flush with nothing held.
    fl = 1'b1;
    cyc();
    fl = 1'b0;
    chk("idle_flushDone", 32'(done), 32'h1);
    chk("idle_no_word", 32'(wval), 32'h0);
    cyc();
    chk("idle_flushDone_off", 32'(done), 32'h0);

    // Full FIFO plus one partial byte: PAD waits for a pop.
    wr = 1'b0;
    for (int i = 0; i <= 16; i++) feed(8'(8'h30 + i));
    fl = 1'b1;
    cyc();
    fl = 1'b0;
    repeat (3) cyc();
    chk("padwait_ready", 32'(rdy), 32'h0);
    chk("padwait_count", 32'(wcnt), 32'd4);
    chk("padwait_done", 32'(done), 32'h0);
    got.delete();
    wr = 1'b1;
    cyc();
    chk("padpush_count", 32'(wcnt), 32'd4);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) begin
        seen = 1;
        break;
      end
      cyc();
    end
    chk("padwait_drained", 32'(seen), 32'h1);
    chk("padwait_last", (got.size() == 5) ? got[4] : 32'hX, 32'h40000000);
    cyc();

    // Asynchronous reset in the middle of a drain.
    wr = 1'b0;
    for (int i = 0; i < 12; i++) feed(8'(8'h50 + i));
    fl = 1'b1;
    cyc();
    fl = 1'b0;
    cyc();
    chk("pre_reset_count", 32'(wcnt), 32'd3);
    #2;
    rstN = 1'b0;
    #1;
    chk("rst_wordValid", 32'(wval), 32'h0);
    chk("rst_wordCount", 32'(wcnt), 32'h0);
    chk("rst_flushDone", 32'(done), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rstN = 1'b1;
    chk("rst_done_after", 32'(done), 32'h0);
    got.delete();
    wr = 1'b1;
    feed(8'hC1);
    feed(8'hC2);
    feed(8'hC3);
    feed(8'hC4);
    repeat (3) cyc();
    chk("resume_word", (got.size() > 0) ? got[0] : 32'hX, 32'hC1C2C3C4);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      we  = ($urandom_range(0, 9) < 7);
      bin = 8'($urandom);
      fl  = ($urandom_range(0, 49) == 0);
      wr  = ($urandom_range(0, 9) < 6);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
